icache_2way_param: RTL and testbench

//  Read-only, 2-way set-associative instruction cache. Parametrised successor of the

---
 rtl/icache_2way_param_if.sv | 34 +++
 rtl/icache_2way_param.sv | 129 ++++++++++++
 tb/tb_icache_2way_param.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_2way_param_if.sv
// rtl/icache_2way_param_if.sv - fetch-port and line-memory bundle for the 2-way I-cache
//
// Purpose: groups the processor fetch port and the line-wide memory port.
// Ports (slave = cache side):
//   proc_read, proc_flush, proc_addr   fetch request, flush, word address (to cache)
//   proc_rdata, proc_stall             fetched word, request-not-complete (from cache)
//   mem_read, mem_addr                 line fetch request and line address (from cache)
//   mem_rdata, mem_ready               line data and its one-cycle valid pulse (to cache)
interface icache_2way_param_if #(
  parameter int ADDR_W     = 30,
  parameter int LINE_WORDS = 4
);
  localparam int OFS = $clog2(LINE_WORDS);

  logic                      proc_read;
  logic                      proc_flush;
  logic [ADDR_W-1:0]         proc_addr;
  logic [31:0]               proc_rdata;
  logic                      proc_stall;
  logic                      mem_read;
  logic [ADDR_W-OFS-1:0]     mem_addr;
  logic [32*LINE_WORDS-1:0]  mem_rdata;
  logic                      mem_ready;

  modport slave (
    input  proc_read, proc_flush, proc_addr, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_addr
  );

  modport master (
    output proc_read, proc_flush, proc_addr, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_addr
  );
endinterface

// File: rtl/icache_2way_param.sv
// rtl/icache_2way_param.sv - read-only 2-way set-associative instruction cache with LRU
//
// Purpose: zero-stall hit path, per-set LRU replacement, single-cycle flush,
//   line fill from a line-wide memory. Optional critical-word forwarding is
//   enabled by defining ICACHE_CRIT_FWD_EN.
// Ports:
//   clk           clock, all state on posedge
//   proc_reset_n  synchronous active-low reset
//   bus           icache_2way_param_if.slave (fetch port + line memory port)
module icache_2way_param #(
  parameter int ADDR_W     = 30,
  parameter int SET_BITS   = 3,
  parameter int LINE_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 proc_reset_n,
  icache_2way_param_if.slave   bus
);
  localparam int OFS    = $clog2(LINE_WORDS);
  localparam int SETS   = 1 << SET_BITS;
  localparam int TAG_W  = ADDR_W - SET_BITS - OFS;
  localparam int LINE_W = 32 * LINE_WORDS;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FETCH = 1'b1;

  logic [0:0]        state;
  logic [SETS-1:0]   valid0, valid1, lru;
  logic [TAG_W-1:0]  tag0  [SETS];
  logic [TAG_W-1:0]  tag1  [SETS];
  logic [LINE_W-1:0] data0 [SETS];
  logic [LINE_W-1:0] data1 [SETS];

  logic [OFS-1:0]      off;
  logic [SET_BITS-1:0] idx, fidx;
  logic [TAG_W-1:0]    tag, ftag;
  logic                hit0, hit1, lookup, hit, fill, fwd, victim;
  logic [LINE_W-1:0]   hit_line;

  assign off  = bus.proc_addr[OFS-1:0];
  assign idx  = bus.proc_addr[OFS+SET_BITS-1:OFS];
  assign tag  = bus.proc_addr[ADDR_W-1:OFS+SET_BITS];
  // The fill target comes from the registered line address, so it stays
  // consistent for the whole fetch regardless of proc_addr.
  assign fidx = bus.mem_addr[SET_BITS-1:0];
  assign ftag = bus.mem_addr[ADDR_W-OFS-1:SET_BITS];

  assign hit0     = valid0[idx] && (tag0[idx] == tag);
  assign hit1     = valid1[idx] && (tag1[idx] == tag);
  assign lookup   = proc_reset_n && (state == IDLE) && !bus.proc_flush && bus.proc_read;
  assign hit      = lookup && (hit0 || hit1);
  assign hit_line = hit0 ? data0[idx] : data1[idx];
  assign fill     = (state == FETCH) && bus.mem_ready;

  // First invalid way (way0 preferred), otherwise the least recently used one.
  assign victim = !valid0[fidx] ? 1'b0 : (!valid1[fidx] ? 1'b1 : lru[fidx]);

`ifdef ICACHE_CRIT_FWD_EN
  assign fwd = proc_reset_n && fill;
`else
  assign fwd = 1'b0;
`endif

  always_comb begin
    bus.proc_stall = 1'b1;
    bus.proc_rdata = 32'h0;
    if (!proc_reset_n) begin
      bus.proc_stall = 1'b1;
    end else if (hit) begin
      bus.proc_stall = 1'b0;
      bus.proc_rdata = hit_line[{off, 5'b0} +: 32];
    end else if (fwd) begin
      bus.proc_stall = 1'b0;
      bus.proc_rdata = bus.mem_rdata[{off, 5'b0} +: 32];
    end else if ((state == IDLE) && !bus.proc_flush && !bus.proc_read) begin
      bus.proc_stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!proc_reset_n) begin
      state        <= IDLE;
      valid0       <= '0;
      valid1       <= '0;
      lru          <= '0;
      bus.mem_read <= 1'b0;
      bus.mem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.proc_flush) begin
            valid0 <= '0;
            valid1 <= '0;
          end else if (bus.proc_read) begin
            if (hit0 || hit1) begin
              lru[idx] <= hit0;
            end else begin
              state        <= FETCH;
              bus.mem_read <= 1'b1;
              bus.mem_addr <= bus.proc_addr[ADDR_W-1:OFS];
            end
          end
        end
        default: begin
          if (bus.mem_ready) begin
            if (victim) valid1[fidx] <= 1'b1;
            else        valid0[fidx] <= 1'b1;
            lru[fidx]    <= ~victim;
            bus.mem_read <= 1'b0;
            state        <= IDLE;
          end
        end
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (proc_reset_n && fill) begin
      if (victim) begin
        tag1[fidx]  <= ftag;
        data1[fidx] <= bus.mem_rdata;
      end else begin
        tag0[fidx]  <= ftag;
        data0[fidx] <= bus.mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_icache_2way_param.sv
// tb/tb_icache_2way_param.sv - self-checking bench for icache_2way_param
module tb_icache_2way_param;
  localparam int ADDR_W = 30;
  localparam int SET_BITS = 3;
  localparam int LINE_WORDS = 4;
  localparam int OFS = 2;
  localparam int SETS = 8;
  localparam int LAT = 3;
`ifdef ICACHE_CRIT_FWD_EN
  localparam bit FWD = 1'b1;
  localparam int MISS_CYC = 4;
`else
  localparam bit FWD = 1'b0;
  localparam int MISS_CYC = 5;
`endif

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  icache_2way_param_if #(.ADDR_W(ADDR_W), .LINE_WORDS(LINE_WORDS)) ifc ();

  icache_2way_param #(.ADDR_W(ADDR_W), .SET_BITS(SET_BITS), .LINE_WORDS(LINE_WORDS)) dut (
    .clk(clk),
    .proc_reset_n(rstn),
    .bus(ifc)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  logic [127:0] mem_img [int];

  function automatic logic [127:0] line_of(input int la);
    logic [127:0] l;
    if (mem_img.exists(la)) return mem_img[la];
    for (int k = 0; k < 4; k++) l[32*k +: 32] = (32'(la) << 4) ^ 32'(k) ^ 32'h5A00_0000;
    return l;
  endfunction

  // Line memory: answers a request LAT cycles after it is first seen, and
  // keeps counting even if the request disappears (reset abort).
  int cd = 0;
  int req_la = 0;
  initial begin
    ifc.mem_ready = 1'b0;
    ifc.mem_rdata = {4{32'hDEAD_BEEF}};
    forever begin
      @(posedge clk); #1;
      ifc.mem_ready = 1'b0;
      ifc.mem_rdata = {4{32'hDEAD_BEEF}};
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          ifc.mem_ready = 1'b1;
          ifc.mem_rdata = line_of(req_la);
        end
      end else if (ifc.mem_read === 1'b1) begin
        cd = LAT;
        req_la = int'(ifc.mem_addr);
      end
    end
  end

  // Model: per set a two-entry recency list of resident line addresses.
  bit m_on = 1'b0;
  bit m_pend = 1'b0;
  int m_la = 0;
  bit m_mem_read = 1'b0;
  int m_mem_addr = 0;
  int mru [SETS];
  int lrl [SETS];
  int cnt [SETS];
  logic [127:0] cdata [int];

  function automatic bit m_has(input int la);
    int s = la & (SETS - 1);
    return (cnt[s] >= 1 && mru[s] == la) || (cnt[s] == 2 && lrl[s] == la);
  endfunction

  task automatic model_step();
    int la, s;
    la = int'(ifc.proc_addr[ADDR_W-1:OFS]);
    if (!rstn) begin
      m_on = 1'b1; m_pend = 1'b0; m_mem_read = 1'b0; m_mem_addr = 0;
      for (int i = 0; i < SETS; i++) cnt[i] = 0;
    end else if (m_on) begin
      if (!m_pend) begin
        if (ifc.proc_flush) begin
          for (int i = 0; i < SETS; i++) cnt[i] = 0;
        end else if (ifc.proc_read) begin
          s = la & (SETS - 1);
          if (m_has(la)) begin
            if (cnt[s] == 2 && lrl[s] == la) begin lrl[s] = mru[s]; mru[s] = la; end
          end else begin
            m_pend = 1'b1; m_la = la; m_mem_read = 1'b1; m_mem_addr = la;
          end
        end
      end else if (ifc.mem_ready) begin
        s = m_la & (SETS - 1);
        if (cnt[s] >= 1) lrl[s] = mru[s];
        mru[s] = m_la;
        if (cnt[s] < 2) cnt[s]++;
        cdata[m_la] = line_of(m_la);
        m_pend = 1'b0;
        m_mem_read = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    logic [31:0] e_rdata;
    logic [127:0] ln;
    bit e_stall, chk_stall;
    int la, off;
    @(negedge clk);
    if (m_on) begin
      la = int'(ifc.proc_addr[ADDR_W-1:OFS]);
      off = int'(ifc.proc_addr[OFS-1:0]);
      e_rdata = 32'h0; e_stall = 1'b1; chk_stall = 1'b1;
      if (!rstn) begin
        e_stall = 1'b1;
      end else if (!m_pend) begin
        if (ifc.proc_flush) e_stall = 1'b1;
        else if (ifc.proc_read) begin
          if (m_has(la)) begin
            ln = cdata[la];
            e_stall = 1'b0; e_rdata = ln[32*off +: 32];
          end
        end else chk_stall = 1'b0;
      end else if (FWD && ifc.mem_ready) begin
        e_stall = 1'b0; e_rdata = ifc.mem_rdata[32*off +: 32];
      end
      if (chk_stall) check("cyc_stall", ifc.proc_stall, e_stall);
      check("cyc_rdata", ifc.proc_rdata, e_rdata);
      check("cyc_mem_read", ifc.mem_read, m_mem_read);
      check("cyc_mem_addr", ifc.mem_addr, m_mem_addr);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [29:0] a, output logic [31:0] d, output int cyc,
                         output logic mr_first, output logic [27:0] ma_first, output logic mr_done);
    bit done = 1'b0;
    ifc.proc_read = 1'b1; ifc.proc_addr = a;
    d = 32'h0; cyc = 0; mr_first = 1'b0; ma_first = '0; mr_done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (i == 1) begin mr_first = ifc.mem_read; ma_first = ifc.mem_addr; end
      if (ifc.proc_stall === 1'b0) begin
        done = 1'b1; d = ifc.proc_rdata; mr_done = ifc.mem_read;
      end else begin
        tick(); cyc++;
      end
    end
    check("read_done", done, 1'b1);
    tick();
    ifc.proc_read = 1'b0;
  endtask

  task automatic pulse_flush();
    ifc.proc_flush = 1'b1;
    tick();
    ifc.proc_flush = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int cyc;
    logic mr1, mrd;
    logic [27:0] ma1;
    rstn = 1'b0; ifc.proc_read = 1'b0; ifc.proc_flush = 1'b0; ifc.proc_addr = '0;
    tick(); tick();
    @(negedge clk);
    check("rst_stall", ifc.proc_stall, 1'b1);
    check("rst_rdata", ifc.proc_rdata, 32'h0);
    check("rst_mem_read", ifc.mem_read, 1'b0);
    check("rst_mem_addr", ifc.mem_addr, 28'h0);
    tick();
    rstn = 1'b1;

    // 1: cold miss on 0x10
    mem_img[4] = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    do_read(30'h10, d, cyc, mr1, ma1, mrd);
    check("t1_rdata", d, 32'hA0);
    check("t1_cycles", cyc, MISS_CYC);
    check("t1_mem_read", mr1, 1'b1);
    check("t1_mem_addr", ma1, 28'h4);
    check("t1_mem_read_done", mrd, FWD);

    // 2: hit on same line
    do_read(30'h13, d, cyc, mr1, ma1, mrd);
    check("t2_rdata", d, 32'hA3);
    check("t2_cycles", cyc, 0);
    check("t2_mem_read", mrd, 1'b0);

    // 3: LRU in set 0
    do_read(30'h00, d, cyc, mr1, ma1, mrd);
    check("t3_miss00", cyc > 0, 1'b1);
    check("t3_rdata00", d, 32'h5A00_0000);
    do_read(30'h20, d, cyc, mr1, ma1, mrd);
    check("t3_miss20", cyc > 0, 1'b1);
    check("t3_rdata20", d, 32'h5A00_0080);
    do_read(30'h00, d, cyc, mr1, ma1, mrd);
    check("t3_hit00", cyc, 0);
    do_read(30'h40, d, cyc, mr1, ma1, mrd);
    check("t3_miss40", cyc > 0, 1'b1);
    check("t3_rdata40", d, 32'h5A00_0100);
    do_read(30'h00, d, cyc, mr1, ma1, mrd);
    check("t3_hit00b", cyc, 0);
    do_read(30'h20, d, cyc, mr1, ma1, mrd);
    check("t3_evicted20", cyc > 0, 1'b1);

    // 4: flush
    do_read(30'h10, d, cyc, mr1, ma1, mrd);
    check("t4_hit10", cyc, 0);
    ifc.proc_flush = 1'b1;
    @(negedge clk);
    check("t4_flush_stall", ifc.proc_stall, 1'b1);
    tick();
    ifc.proc_flush = 1'b0;
    do_read(30'h10, d, cyc, mr1, ma1, mrd);
    check("t4_miss10", cyc > 0, 1'b1);
    check("t4_mem_read", mr1, 1'b1);
    ifc.proc_read = 1'b1; ifc.proc_flush = 1'b1; ifc.proc_addr = 30'h10;
    @(negedge clk);
    check("t4_flush_wins_stall", ifc.proc_stall, 1'b1);
    check("t4_flush_wins_rdata", ifc.proc_rdata, 32'h0);
    tick();
    ifc.proc_flush = 1'b0;
    do_read(30'h10, d, cyc, mr1, ma1, mrd);
    check("t4_miss_after_fr", cyc > 0, 1'b1);

    // 5: reset during fetch
    pulse_flush();
    ifc.proc_read = 1'b1; ifc.proc_addr = 30'h10;
    tick();
    rstn = 1'b0;
    @(negedge clk);
    check("t5_fetch_mem_read", ifc.mem_read, 1'b1);
    tick();
    rstn = 1'b1; ifc.proc_read = 1'b0;
    @(negedge clk);
    check("t5_abort_mem_read", ifc.mem_read, 1'b0);
    repeat (6) tick();
    do_read(30'h10, d, cyc, mr1, ma1, mrd);
    check("t5_miss_after_rst", cyc > 0, 1'b1);
    check("t5_mem_read", mr1, 1'b1);

    // 6: critical word
    pulse_flush();
    mem_img[4] = {32'hC3, 32'h55, 32'hC1, 32'hC0};
    do_read(30'h12, d, cyc, mr1, ma1, mrd);
    check("t6_rdata", d, 32'h55);
    check("t6_cycles", cyc, MISS_CYC);

    // wrap / high tags in set 7
    do_read(30'h3FFF_FFFD, d, cyc, mr1, ma1, mrd);
    check("hi_rdata", d, 32'hA5FF_FFF1);
    do_read(30'h1D, d, cyc, mr1, ma1, mrd);
    do_read(30'h3FFF_FFFE, d, cyc, mr1, ma1, mrd);
    check("hi_hit", cyc, 0);
    do_read(30'h3D, d, cyc, mr1, ma1, mrd);
    do_read(30'h1C, d, cyc, mr1, ma1, mrd);
    check("set7_evicted", cyc > 0, 1'b1);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end
endmodule
